// File: rtl/sync_fifo_cbb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_cbb_pkg -- read-style constants, counter width, pointer compare |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sync_fifo_cbb_pkg;

  localparam logic [47:0] C_ATTR_NORMAL = "normal";
  localparam logic [47:0] C_ATTR_AHEAD  = {8'h00, "ahead"};
  localparam int unsigned C_ERR_CNT_W   = 16;

  // Pointers carry one wrap bit above the address; only aw+1 bits are compared.
  function automatic logic ptr_is_empty(input logic [31:0] wp, input logic [31:0] rp,
                                        input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd2 << aw) - 32'd1;
    return ((wp ^ rp) & mask) == 32'd0;
  endfunction

  function automatic logic ptr_is_full(input logic [31:0] wp, input logic [31:0] rp,
                                       input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd2 << aw) - 32'd1;
    return ((wp ^ rp) & mask) == (32'd1 << aw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram_cbb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdp_ram_cbb -- simple dual-port RAM, registered read, no reset           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sdp_ram_cbb #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk_wr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk_wr) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/sync_fifo_cbb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_cbb -- single-clock FIFO, "normal"/"ahead" read style.         |
// | Define SYNC_FIFO_CBB_ERR_CNT_EN for ovf_cnt/udf_cnt. Rev 1.0             |
// +--------------------------------------------------------------------------+
module sync_fifo_cbb
  import sync_fifo_cbb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter logic [47:0] FIFO_ATTR  = C_ATTR_NORMAL,
  parameter int unsigned AFULL_TH   = 2**ADDR_WIDTH - 8,
  parameter int unsigned AEMPTY_TH  = 8
) (
  input  logic                  clk_wr,
  input  logic                  wr_reset,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
`ifdef SYNC_FIFO_CBB_ERR_CNT_EN
  ,
  output logic [C_ERR_CNT_W-1:0] ovf_cnt,
  output logic [C_ERR_CNT_W-1:0] udf_cnt
`endif
);

  logic [ADDR_WIDTH:0]   r_wptr, r_rptr;
  logic [ADDR_WIDTH:0]   w_wptr_nxt, w_rptr_nxt, w_count_nxt;
  logic                  w_wr_acc, w_rd_acc;
  logic                  w_ram_rd_en;
  logic [ADDR_WIDTH-1:0] w_ram_rd_addr;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign w_wr_acc    = wen & ~full;
  assign w_rd_acc    = ren & ~empty;
  assign w_wptr_nxt  = r_wptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
  assign w_rptr_nxt  = r_rptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
  assign w_count_nxt = w_wptr_nxt - w_rptr_nxt;

  always_ff @(posedge clk_wr or posedge wr_reset) begin
    if (wr_reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      count     <= w_count_nxt;
      full      <= ptr_is_full(32'(w_wptr_nxt), 32'(w_rptr_nxt), ADDR_WIDTH);
      empty     <= ptr_is_empty(32'(w_wptr_nxt), 32'(w_rptr_nxt), ADDR_WIDTH);
      afull     <= (32'(w_count_nxt) >= AFULL_TH);
      aempty    <= (32'(w_count_nxt) <= AEMPTY_TH);
      overflow  <= wen & full;
      underflow <= ren & empty;
    end
  end

  sdp_ram_cbb #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_wr  (clk_wr),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wptr[ADDR_WIDTH-1:0]),
    .wr_data (wdata),
    .rd_en   (w_ram_rd_en),
    .rd_addr (w_ram_rd_addr),
    .rd_data (w_ram_q)
  );

  generate
    if (FIFO_ATTR == C_ATTR_AHEAD) begin : g_ahead
      logic                  r_byp;
      logic [DATA_WIDTH-1:0] r_byp_data;

      // RAM continuously prefetches the post-update head; a write landing on
      // that slot is read-first in the RAM, so it is forwarded instead.
      assign w_ram_rd_en   = 1'b1;
      assign w_ram_rd_addr = w_rptr_nxt[ADDR_WIDTH-1:0];

      always_ff @(posedge clk_wr or posedge wr_reset) begin
        if (wr_reset) begin
          r_byp      <= 1'b0;
          r_byp_data <= '0;
        end else begin
          r_byp <= w_wr_acc && (r_wptr == w_rptr_nxt);
          if (w_wr_acc) r_byp_data <= wdata;
        end
      end

      assign rdata = empty ? '0 : (r_byp ? r_byp_data : w_ram_q);
    end else begin : g_normal
      logic r_out_vld;

      assign w_ram_rd_en   = w_rd_acc;
      assign w_ram_rd_addr = r_rptr[ADDR_WIDTH-1:0];

      // The RAM output has no reset, so it is masked until the first read.
      always_ff @(posedge clk_wr or posedge wr_reset) begin
        if (wr_reset)      r_out_vld <= 1'b0;
        else if (w_rd_acc) r_out_vld <= 1'b1;
      end

      assign rdata = r_out_vld ? w_ram_q : '0;
    end
  endgenerate

`ifdef SYNC_FIFO_CBB_ERR_CNT_EN
  always_ff @(posedge clk_wr or posedge wr_reset) begin
    if (wr_reset) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (overflow  && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
      if (underflow && (udf_cnt != '1)) udf_cnt <= udf_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_cbb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sync_fifo_cbb -- queue-model bench for normal and ahead FIFO instances |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sync_fifo_cbb;
  import sync_fifo_cbb_pkg::*;

  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 8;
  localparam int AE_TH = 8;

  logic          clk_wr   = 1'b0;
  logic          wr_reset = 1'b1;
  logic          wen      = 1'b0;
  logic          ren      = 1'b0;
  logic [DW-1:0] wdata    = '0;

  logic [DW-1:0] n_rdata, a_rdata;
  logic          n_full, n_empty, n_afull, n_aempty, n_ovf, n_udf;
  logic          a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
  logic [AW:0]   n_count, a_count;
`ifdef SYNC_FIFO_CBB_ERR_CNT_EN
  logic [15:0]   n_ovf_cnt, n_udf_cnt, a_ovf_cnt, a_udf_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk_wr = ~clk_wr;

  sync_fifo_cbb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_ATTR(C_ATTR_NORMAL),
                  .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)) u_nrm (
    .clk_wr(clk_wr), .wr_reset(wr_reset), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(n_rdata), .full(n_full), .empty(n_empty), .afull(n_afull), .aempty(n_aempty),
    .count(n_count), .overflow(n_ovf), .underflow(n_udf)
`ifdef SYNC_FIFO_CBB_ERR_CNT_EN
    , .ovf_cnt(n_ovf_cnt), .udf_cnt(n_udf_cnt)
`endif
  );

  sync_fifo_cbb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_ATTR(C_ATTR_AHEAD),
                  .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)) u_ahd (
    .clk_wr(clk_wr), .wr_reset(wr_reset), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(a_rdata), .full(a_full), .empty(a_empty), .afull(a_afull), .aempty(a_aempty),
    .count(a_count), .overflow(a_ovf), .underflow(a_udf)
`ifdef SYNC_FIFO_CBB_ERR_CNT_EN
    , .ovf_cnt(a_ovf_cnt), .udf_cnt(a_udf_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of stored words.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last = '0;
  bit            m_ovf  = 1'b0;
  bit            m_udf  = 1'b0;
  int            m_sz;

  always @(posedge clk_wr or posedge wr_reset) begin
    if (wr_reset) begin
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      m_sz  = mq.size();
      m_ovf = wen && (m_sz == DEPTH);
      m_udf = ren && (m_sz == 0);
      if (ren && m_sz > 0)     m_last = mq.pop_front();
      if (wen && m_sz < DEPTH) mq.push_back(wdata);
    end
  end

  always @(negedge clk_wr) begin
    if (chk_on) begin
      chk("n_count",  32'(n_count),  32'(mq.size()));
      chk("a_count",  32'(a_count),  32'(mq.size()));
      chk("n_full",   32'(n_full),   32'(mq.size() == DEPTH));
      chk("a_full",   32'(a_full),   32'(mq.size() == DEPTH));
      chk("n_empty",  32'(n_empty),  32'(mq.size() == 0));
      chk("a_empty",  32'(a_empty),  32'(mq.size() == 0));
      chk("n_afull",  32'(n_afull),  32'(mq.size() >= AF_TH));
      chk("a_afull",  32'(a_afull),  32'(mq.size() >= AF_TH));
      chk("n_aempty", 32'(n_aempty), 32'(mq.size() <= AE_TH));
      chk("a_aempty", 32'(a_aempty), 32'(mq.size() <= AE_TH));
      chk("n_ovf",    32'(n_ovf),    32'(m_ovf));
      chk("a_ovf",    32'(a_ovf),    32'(m_ovf));
      chk("n_udf",    32'(n_udf),    32'(m_udf));
      chk("a_udf",    32'(a_udf),    32'(m_udf));
      chk("n_rdata",  32'(n_rdata),  32'(m_last));
      if (mq.size() > 0) chk("a_rdata_head", 32'(a_rdata), 32'(mq[0]));
    end
  end

  // One clock with the given inputs; returns #1 after the edge with inputs idle.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r);
    wen = w; wdata = d; ren = r;
    @(posedge clk_wr); #1;
    wen = 1'b0; ren = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk_wr);
    #1;
    chk("rst_count",  32'(n_count),  32'd0);
    chk("rst_empty",  32'(a_empty),  32'd1);
    chk("rst_aempty", 32'(n_aempty), 32'd1);
    chk("rst_full",   32'(n_full),   32'd0);
    chk("rst_rdata",  32'(n_rdata),  32'd0);
    wr_reset = 1'b0;
    chk_on   = 1'b1;

    // Fill 16 words; afull from the 8th word.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 9'(i), 1'b0);
      chk("fill_count", 32'(n_count), 32'(i + 1));
      chk("fill_afull", 32'(n_afull), (i >= 7) ? 32'd1 : 32'd0);
    end
    chk("fill_full",  32'(n_full),  32'd1);
    chk("fill_cnt16", 32'(a_count), 32'd16);

    cyc(1'b1, 9'h0FF, 1'b0);
    chk("ovf_pulse", 32'(n_ovf),   32'd1);
    chk("ovf_count", 32'(n_count), 32'd16);
    cyc(1'b0, 9'h000, 1'b0);
    chk("ovf_clear", 32'(a_ovf),   32'd0);

    // Drain: each word 1 cycle after its ren.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 9'h000, 1'b1);
      chk("drain_rdata", 32'(n_rdata), 32'(i));
    end
    chk("drain_empty", 32'(n_empty), 32'd1);

    cyc(1'b0, 9'h000, 1'b1);
    chk("udf_pulse", 32'(n_udf),   32'd1);
    chk("udf_hold",  32'(n_rdata), 32'h00F);

    // Ahead: single write must surface within 2 cycles without ren.
    cyc(1'b1, 9'h1A5, 1'b0);
    k = 0;
    while (!(a_empty == 1'b0 && a_rdata == 9'h1A5) && k < 1) begin
      cyc(1'b0, 9'h000, 1'b0);
      k++;
    end
    chk("ahead_first_rdata", 32'(a_rdata), 32'h1A5);
    chk("ahead_first_empty", 32'(a_empty), 32'd0);
    cyc(1'b0, 9'h000, 1'b1);
    chk("ahead_pop_nrm", 32'(n_rdata), 32'h1A5);

    // Steady state at count=5 with simultaneous wen/ren for 40 cycles.
    for (int i = 0; i < 5; i++) cyc(1'b1, 9'(9'h100 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 9'(9'h105 + i), 1'b1);
      chk("rw_rdata", 32'(n_rdata), 32'(9'h100 + i));
      chk("rw_count", 32'(a_count), 32'd5);
    end

    // Reset with 10 words stored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 9'(9'h12D + i), 1'b0);
    chk("pre_rst_count", 32'(n_count), 32'd10);
    @(posedge clk_wr); #3;
    wr_reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(n_count), 32'd0);
    chk("async_rst_empty", 32'(a_empty), 32'd1);
    @(posedge clk_wr); #1;
    wr_reset = 1'b0;
    cyc(1'b1, 9'h0AA, 1'b0);
    chk("post_rst_ahead", 32'(a_rdata), 32'h0AA);
    cyc(1'b0, 9'h000, 1'b1);
    chk("post_rst_nrm",   32'(n_rdata), 32'h0AA);

`ifdef SYNC_FIFO_CBB_ERR_CNT_EN
    @(posedge clk_wr); #1;
    wr_reset = 1'b1;
    @(posedge clk_wr); #1;
    wr_reset = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 9'(i), 1'b0);
    wen = 1'b1;
    repeat (70000) @(posedge clk_wr);
    #1;
    wen = 1'b0;
    cyc(1'b0, 9'h000, 1'b0);
    cyc(1'b0, 9'h000, 1'b0);
    chk("ovf_cnt_sat", 32'(n_ovf_cnt), 32'h0000FFFF);
    chk("ovf_cnt_sat_a", 32'(a_ovf_cnt), 32'h0000FFFF);
    chk("udf_cnt_zero", 32'(n_udf_cnt), 32'd0);
`endif

    @(posedge clk_wr); #1;
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_cbb.md
SYNC_FIFO_CBB -- requirements
Module: sync_fifo_cbb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, word width including the parity bit (parity-extended word).
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, with depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter FIFO_ATTR, default "normal", read style: "normal" or "ahead".
REQ-004 SHALL have parameter AFULL_TH, default 2**ADDR_WIDTH-8; afull asserts when count >= AFULL_TH.
REQ-005 SHALL have parameter AEMPTY_TH, default 8; aempty asserts when count <= AEMPTY_TH.
REQ-006 SHALL have port clk_wr  input  1  single clock for write and read.
REQ-007 SHALL have port wr_reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port wen  input  1  write enable; comes from the parity generator's fifo_wen.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  write word; comes from the parity generator's fifo_wdata.
REQ-010 SHALL have port ren  input  1  read enable.
REQ-011 SHALL have port rdata  output  DATA_WIDTH  read word; feeds the parity checker's fifo_rdata.
REQ-012 SHALL have ports full, empty, afull, aempty  output  1 each  level flags.
REQ-013 SHALL have port count  output  ADDR_WIDTH+1  stored-word count.
REQ-014 SHALL have ports overflow, underflow  output  1 each  single-cycle error pulses.

Function
REQ-015 Write accepted iff wen=1 and full=0: word stored at wptr, wptr increments modulo depth.
REQ-016 Read accepted iff ren=1 and empty=0: rptr increments modulo depth.
REQ-017 Pointers SHALL be ADDR_WIDTH+1 bits; empty when pointers are equal; full when MSBs differ and the lower bits are equal.
REQ-018 count = wptr - rptr in ADDR_WIDTH+1 bits; updated in the cycle after an accepted operation.
REQ-019 All flags SHALL be registered and derived from the post-update pointers, so they are exact on the cycle after each operation.
REQ-020 "normal": rdata SHALL present the word exactly 1 cycle after the accepted read and hold it until the next accepted read.
REQ-021 "ahead": rdata SHALL show the head word whenever empty=0; an accepted read SHALL advance rdata to the next word in the following cycle.
REQ-022 "ahead": the first write into an empty FIFO SHALL appear on rdata with empty=0 no later than 2 cycles after the write.
REQ-023 Simultaneous accepted read and write SHALL leave count and flags unchanged.
REQ-024 Simultaneous read and write when full: the read SHALL be accepted and the write rejected.
REQ-025 Simultaneous read and write when empty: the write SHALL be accepted and the read rejected.
REQ-026 wen=1 while full SHALL drop the data and pulse overflow for 1 cycle.
REQ-027 ren=1 while empty SHALL pulse underflow for 1 cycle; rdata is unchanged.
REQ-028 A rejected operation SHALL never move a pointer.
REQ-029 Pointer wrap from depth-1 to 0 SHALL be seamless, with no lost or duplicated word.

Reset
REQ-030 wr_reset=1 SHALL asynchronously clear both pointers, count, rdata, overflow, underflow, full and afull.
REQ-031 During reset, empty=1 and aempty=1.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset mid-operation SHALL discard all stored data; the first cycle after deassertion behaves as an empty FIFO.

Configuration
REQ-034 Macro SYNC_FIFO_CBB_ERR_CNT_EN defined: SHALL add outputs ovf_cnt[15:0] and udf_cnt[15:0], incremented on each overflow/underflow pulse.
REQ-035 These counters SHALL saturate at 16'hFFFF and be cleared by wr_reset.
REQ-036 Macro undefined: the ports and logic are absent; all other behaviour is identical.

Structure
REQ-037 Shared package sync_fifo_cbb_pkg SHALL hold the FIFO_ATTR string constants, the counter width constant (16) and the pointer-compare helper functions.
REQ-038 Storage SHALL be one sub-module, sdp_ram_cbb: simple dual-port, 1-cycle registered read, no reset.
REQ-039 Pointer, flag and prefetch logic SHALL be in sync_fifo_cbb.

Verification
REQ-040 Bench SHALL cover: ADDR_WIDTH=4, write 16 words 0x000..0x00F -> full=1, count=16, afull=1 from count 8 (AFULL_TH=8); a 17th write -> overflow pulse, count stays 16.
REQ-041 Bench SHALL cover: "normal", after the fill, read 16 -> rdata 0x000..0x00F, each 1 cycle after ren, empty=1 after the last; an extra ren -> underflow pulse.
REQ-042 Bench SHALL cover: "ahead", a single write of 0x1A5 into empty -> rdata=0x1A5 with empty=0 within 2 cycles, before any ren.
REQ-043 Bench SHALL cover: simultaneous wen/ren for 40 cycles at count=5 with ADDR_WIDTH=4 -> count stays 5, pointers wrap twice, output equals the input order.
REQ-044 Bench SHALL cover: wr_reset pulse with count=10 -> count=0, empty=1 immediately; the next written word is the next read word.
REQ-045 Bench SHALL cover, with SYNC_FIFO_CBB_ERR_CNT_EN defined: 70000 writes into a full FIFO -> ovf_cnt=16'hFFFF.
